// File: rtl/sdfm_pkg.sv
// Shared constants and helpers for the multi-channel sigma-delta filter array.
package sdfm_pkg;

    typedef enum logic [1:0] {
        SINC1   = 2'd0,
        SINC2   = 2'd1,
        SINC3   = 2'd2,
        SINC3_X = 2'd3
    } sinc_order_t;

    // Three integrator stages of 8-bit decimation growth plus the input bit.
    localparam int unsigned ACCW_MIN = 3 * 8 + 1;

    function automatic logic [1:0] order_taps(input sinc_order_t st);
        case (st)
            SINC1:   return 2'd1;
            SINC2:   return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    function automatic int unsigned chan_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sdfm_sinc_filt.sv
// One sigma-delta channel: input sync, config latch, sinc1..3 filter, settle discard, pending slot.
module sdfm_sinc_filt
    import sdfm_pkg::*;
#(
    parameter int unsigned ACCW = ACCW_MIN,
    parameter int unsigned DW   = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sdclk_i,
    input  logic          dsdin_i,
    input  logic          en_i,
    input  logic [7:0]    dec_i,
    input  logic [1:0]    st_i,
    input  logic [4:0]    sh_i,
    input  logic          ovf_clr_i,
    input  logic          grant_i,
    output logic          pend_valid_o,
    output logic [DW-1:0] pend_data_o,
    output logic          ovf_o
);

    logic [2:0]      sclk_q, sdin_q;
    logic            smp_q, en_q;
    logic [7:0]      dec_q, cnt_q;
    sinc_order_t     st_q;
    logic [4:0]      sh_q;
    logic [1:0]      settle_q;
    logic [ACCW-1:0] i1_q, i2_q, i3_q, d1_q, d2_q, d3_q;
    logic            pend_valid_q, ovf_q;
    logic [DW-1:0]   pend_data_q;

    logic [ACCW-1:0] x, i1_d, i2_d, i3_d, sel, c1, c2, c3, res;
    logic [1:0]      taps;
    logic            active, wrap, fire, keep;
    logic            pend_valid_d, ovf_d;
    logic [DW-1:0]   pend_data_d;

    // Integrate on every sample, differentiate on the decimation wrap.
    always_comb begin
        x      = ACCW'(sdin_q[2]);
        i1_d   = i1_q + x;
        i2_d   = i2_q + i1_d;
        i3_d   = i3_q + i2_d;
        active = en_i && en_q && smp_q;
        wrap   = (cnt_q == dec_q);
        fire   = active && wrap;
        taps   = order_taps(st_q);
        case (st_q)
            SINC1:   sel = i1_d;
            SINC2:   sel = i2_d;
            default: sel = i3_d;
        endcase
        c1 = sel - d1_q;
        c2 = c1 - d2_q;
        c3 = c2 - d3_q;
        case (st_q)
            SINC1:   res = c1;
            SINC2:   res = c2;
            default: res = c3;
        endcase
        keep = fire && (settle_q == taps);

        pend_valid_d = pend_valid_q;
        pend_data_d  = pend_data_q;
        if (!en_i) begin
            pend_valid_d = 1'b0;
        end else if (keep) begin
            pend_valid_d = 1'b1;
            pend_data_d  = DW'(res >> sh_q);
        end else if (grant_i) begin
            pend_valid_d = 1'b0;
        end

        ovf_d = ovf_q;
        if (keep && pend_valid_q && !grant_i) begin
            ovf_d = 1'b1;
        end else if (ovf_clr_i) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_q       <= '0;
            sdin_q       <= '0;
            smp_q        <= 1'b0;
            en_q         <= 1'b0;
            dec_q        <= '0;
            st_q         <= SINC1;
            sh_q         <= '0;
            cnt_q        <= '0;
            settle_q     <= '0;
            i1_q         <= '0;
            i2_q         <= '0;
            i3_q         <= '0;
            d1_q         <= '0;
            d2_q         <= '0;
            d3_q         <= '0;
            pend_valid_q <= 1'b0;
            pend_data_q  <= '0;
            ovf_q        <= 1'b0;
        end else begin
            sclk_q       <= {sclk_q[1:0], sdclk_i};
            sdin_q       <= {sdin_q[1:0], dsdin_i};
            smp_q        <= sclk_q[1] & ~sclk_q[2];
            en_q         <= en_i;
            pend_valid_q <= pend_valid_d;
            pend_data_q  <= pend_data_d;
            ovf_q        <= ovf_d;
            if (en_i && !en_q) begin
                dec_q <= dec_i;
                st_q  <= sinc_order_t'(st_i);
                sh_q  <= sh_i;
            end
            if (!en_i) begin
                cnt_q    <= '0;
                settle_q <= '0;
                i1_q     <= '0;
                i2_q     <= '0;
                i3_q     <= '0;
                d1_q     <= '0;
                d2_q     <= '0;
                d3_q     <= '0;
            end else if (active) begin
                i1_q  <= i1_d;
                i2_q  <= i2_d;
                i3_q  <= i3_d;
                cnt_q <= wrap ? 8'd0 : cnt_q + 8'd1;
                if (wrap) begin
                    d1_q <= sel;
                    d2_q <= c1;
                    d3_q <= c2;
                    if (settle_q != taps) begin
                        settle_q <= settle_q + 2'd1;
                    end
                end
            end
        end
    end

    assign pend_valid_o = pend_valid_q;
    assign pend_data_o  = pend_data_q;
    assign ovf_o        = ovf_q;

endmodule

// File: rtl/sdfm_channel_array.sv
// NCH sinc filter channels merged by a round-robin arbiter into one registered result FIFO.
module sdfm_channel_array
    import sdfm_pkg::*;
#(
    parameter  int unsigned NCH   = 4,
    parameter  int unsigned ACCW  = ACCW_MIN,
    parameter  int unsigned DW    = 32,
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned CW    = chan_width(NCH),
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             SYSCLK,
    input  logic             SYSRST,
    input  logic [NCH-1:0]   DSDIN,
    input  logic [NCH-1:0]   SDCLK,
    input  logic [NCH-1:0]   reg_filten,
    input  logic [8*NCH-1:0] reg_filtdec,
    input  logic [2*NCH-1:0] reg_filtst,
    input  logic [5*NCH-1:0] reg_filtsh,
    input  logic [NCH-1:0]   ovf_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_data,
    output logic [CW-1:0]    out_chan,
    output logic [NCH-1:0]   ovf,
    output logic [AW:0]      fifo_level
);

    typedef struct packed {
        logic [CW-1:0] chan;
        logic [DW-1:0] data;
    } fifo_entry_t;

    logic [NCH-1:0] pend_valid, grant;
    logic [DW-1:0]  pend_data [NCH];

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        sdfm_sinc_filt #(.ACCW(ACCW), .DW(DW)) u_filt (
            .clk          (SYSCLK),
            .rst          (SYSRST),
            .sdclk_i      (SDCLK[i]),
            .dsdin_i      (DSDIN[i]),
            .en_i         (reg_filten[i]),
            .dec_i        (reg_filtdec[8*i +: 8]),
            .st_i         (reg_filtst[2*i +: 2]),
            .sh_i         (reg_filtsh[5*i +: 5]),
            .ovf_clr_i    (ovf_clr[i]),
            .grant_i      (grant[i]),
            .pend_valid_o (pend_valid[i]),
            .pend_data_o  (pend_data[i]),
            .ovf_o        (ovf[i])
        );
    end

    logic [CW-1:0]  rr_q, gnt_idx;
    logic [AW-1:0]  wptr_q, rptr_q, rptr_d;
    logic [AW:0]    count_q, count_d;
    fifo_entry_t    mem_q [DEPTH];
    fifo_entry_t    new_entry, head_d;
    logic           out_valid_q;
    logic [DW-1:0]  out_data_q;
    logic [CW-1:0]  out_chan_q;
    logic           gnt_vld, push, pop, full;
    int unsigned    scan_idx;

    // Round-robin scan starting at rr_q; the head register is refreshed with the post-update entry.
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        grant    = '0;
        scan_idx = 0;
        for (int unsigned k = 0; k < NCH; k++) begin
            scan_idx = (32'(rr_q) + k) % NCH;
            if (!gnt_vld && pend_valid[CW'(scan_idx)]) begin
                gnt_vld = 1'b1;
                gnt_idx = CW'(scan_idx);
            end
        end
        pop  = out_valid_q && out_ready;
        full = (count_q == (AW+1)'(DEPTH));
        push = gnt_vld && (!full || pop);
        if (push) begin
            grant[gnt_idx] = 1'b1;
        end
        new_entry = '{chan: gnt_idx, data: pend_data[gnt_idx]};
        rptr_d    = pop ? rptr_q + AW'(1) : rptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
        head_d = (push && (wptr_q == rptr_d)) ? new_entry : mem_q[rptr_d];
    end

    always_ff @(posedge SYSCLK or posedge SYSRST) begin
        if (SYSRST) begin
            rr_q        <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_q[wptr_q] <= new_entry;
                wptr_q        <= wptr_q + AW'(1);
                rr_q          <= (gnt_idx == CW'(NCH - 1)) ? '0 : gnt_idx + CW'(1);
            end
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            out_valid_q <= (count_d != '0);
            out_data_q  <= head_d.data;
            out_chan_q  <= head_d.chan;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_chan   = out_chan_q;
    assign fifo_level = count_q;

endmodule
